// File: rtl/gray_rr_arbiter_if.sv
// Handshake bundle between the requesters and the Gray-index round-robin
// arbiter. The master side drives requests and completion; the slave
// (the arbiter) drives the grant and status outputs.
interface gray_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_gray;
  logic       grant_vld;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_gray,
    input  grant_vld,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_gray,
    output grant_vld,
    output timeout
  );
endinterface

// File: rtl/gray_rr_arbiter.sv
// Eight-way round-robin arbiter. The owner is reported as a one-hot grant and
// as a 3-bit Gray-coded index. A grant is held until done, until the owner
// drops its request, or until HOLD_MAX cycles have elapsed. Every release
// passes through one idle cycle before the next grant.
module gray_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_rr_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t     state_q;
  logic [2:0] last_q;
  logic [7:0] cnt_q;
  logic [7:0] grant_q;
  logic [2:0] gray_q;
  logic       vld_q;
  logic       timeout_q;

  logic [2:0] sel_idx_s;
  logic       sel_found_s;
  logic       owner_req_s;

  // One-hot to Gray index encoder (index i maps to i ^ (i >> 1)).
  function automatic logic [2:0] onehot_to_gray(input logic [7:0] oh);
    logic [2:0] g;
    case (oh)
      8'h01:   g = 3'b000;
      8'h02:   g = 3'b001;
      8'h04:   g = 3'b011;
      8'h08:   g = 3'b010;
      8'h10:   g = 3'b110;
      8'h20:   g = 3'b111;
      8'h40:   g = 3'b101;
      8'h80:   g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // Pick the first active request searching upward from last+1 with wrap.
  always_comb begin
    logic [2:0] cand;
    cand        = 3'd0;
    sel_idx_s   = 3'd0;
    sel_found_s = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!sel_found_s && bus.req[cand]) begin
        sel_idx_s   = cand;
        sel_found_s = 1'b1;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // The current owner is still requesting.
  assign owner_req_s = |(bus.req & grant_q);

  // Arbitration FSM with registered grant, Gray index, valid and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 3'd7;
      cnt_q     <= 8'd0;
      grant_q   <= 8'h00;
      gray_q    <= 3'b000;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found_s) begin
            state_q <= BUSY;
            last_q  <= sel_idx_s;
            grant_q <= 8'd1 << sel_idx_s;
            gray_q  <= onehot_to_gray(8'd1 << sel_idx_s);
            vld_q   <= 1'b1;
            // The counter holds the number of the grant cycle now starting.
            cnt_q   <= 8'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (bus.done || !owner_req_s) begin
            state_q <= IDLE;
            grant_q <= 8'h00;
            gray_q  <= 3'b000;
            vld_q   <= 1'b0;
            cnt_q   <= 8'd0;
          end else if (cnt_q == HOLD_MAX_C) begin
            state_q   <= IDLE;
            grant_q   <= 8'h00;
            gray_q    <= 3'b000;
            vld_q     <= 1'b0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 8'h00;
          gray_q  <= 3'b000;
          vld_q   <= 1'b0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_gray = gray_q;
  assign bus.grant_vld  = vld_q;
  assign bus.timeout    = timeout_q;

endmodule
